// File: rtl/if_pkg.sv
// ------------------------------------------------------------------
// if_pkg : shared constants for the IF-stage fetch controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package if_pkg;

  // Next-fetch mux selects
  localparam logic [1:0] SEL_NPC = 2'b00;
  localparam logic [1:0] SEL_TA  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // Control-transfer instruction types
  localparam logic [1:0] CTI_BICC = 2'b00;
  localparam logic [1:0] CTI_CALL = 2'b01;
  localparam logic [1:0] CTI_JMPL = 2'b10;
  localparam logic [1:0] CTI_RSVD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_START    = 2'b00;
  localparam state_t ST_RUN      = 2'b01;
  localparam state_t ST_WAIT_ALU = 2'b10;

  // Delay slot is squashed when annul is set, unless a conditional branch is taken
  function automatic logic bicc_annuls(input logic taken, input logic always_br,
                                       input logic annul_bit);
    return annul_bit && (!taken || always_br);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
// ------------------------------------------------------------------
// if_fetch_ctrl_if : ID/hazard inputs and IF-stage enables of the fetch controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface if_fetch_ctrl_if;
  logic       stall_in;
  logic       cti_valid;
  logic [1:0] cti_type;
  logic       cond_true;
  logic       cond_always;
  logic       annul;
  logic       alu_ready;
  logic       pc_le;
  logic       npc_le;
  logic       ifid_le;
  logic       ch_clear;
  logic [1:0] mux_sel;
  logic       busy;

  modport master (
    input  stall_in, cti_valid, cti_type, cond_true, cond_always, annul, alu_ready,
    output pc_le, npc_le, ifid_le, ch_clear, mux_sel, busy
  );

  modport slave (
    output stall_in, cti_valid, cti_type, cond_true, cond_always, annul, alu_ready,
    input  pc_le, npc_le, ifid_le, ch_clear, mux_sel, busy
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ------------------------------------------------------------------
// if_fetch_ctrl : IF-stage sequencer (delayed CTI with annul, stalls, start-up, JMPL wait)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int STARTUP_CYCLES = 1,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             R,
  if_fetch_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] C_START_LAST = CNT_W'(STARTUP_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic       w_pc_le;
  logic       w_npc_le;
  logic       w_ifid_le;
  logic       w_ch_clear;
  logic [1:0] w_mux_sel;
  logic       w_busy;

  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= ST_START;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_START) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: begin
        if (r_cnt == C_START_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.stall_in && bus.cti_valid && bus.cti_type == CTI_JMPL)
          w_state_nxt = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        if (bus.alu_ready && !bus.stall_in) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_comb begin
    w_pc_le    = 1'b0;
    w_npc_le   = 1'b0;
    w_ifid_le  = 1'b0;
    w_ch_clear = 1'b0;
    w_mux_sel  = SEL_NPC;
    w_busy     = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Stall wins; any CTI in ID is simply re-presented once it releases
        if (!bus.stall_in) begin
          if (!bus.cti_valid) begin
            {w_pc_le, w_npc_le, w_ifid_le} = 3'b111;
          end else begin
            case (bus.cti_type)
              CTI_BICC: begin
                {w_pc_le, w_npc_le, w_ifid_le} = 3'b111;
                w_mux_sel  = bus.cond_true ? SEL_TA : SEL_NPC;
                w_ch_clear = bicc_annuls(bus.cond_true, bus.cond_always, bus.annul);
              end
              CTI_CALL: begin
                {w_pc_le, w_npc_le, w_ifid_le} = 3'b111;
                w_mux_sel = SEL_TA;
              end
              CTI_JMPL: begin
                // Delay slot moves into ID while PC waits for the EX-stage target
                w_ifid_le = 1'b1;
              end
              CTI_RSVD: begin
                {w_pc_le, w_npc_le, w_ifid_le} = 3'b111;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WAIT_ALU: begin
        // Bubble keeps the already-issued delay slot from issuing again
        w_ch_clear = 1'b1;
        w_busy     = 1'b1;
        if (bus.alu_ready && !bus.stall_in) begin
          w_pc_le   = 1'b1;
          w_npc_le  = 1'b1;
          w_mux_sel = SEL_ALU;
        end
      end
      default: begin
        w_ch_clear = 1'b1;
        w_busy     = 1'b1;
      end
    endcase
  end

  assign bus.pc_le    = w_pc_le;
  assign bus.npc_le   = w_npc_le;
  assign bus.ifid_le  = w_ifid_le;
  assign bus.ch_clear = w_ch_clear;
  assign bus.mux_sel  = w_mux_sel;
  assign bus.busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ------------------------------------------------------------------
// tb_if_fetch_ctrl : directed vector table plus randomized run against a reference model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_ctrl;

  typedef struct packed {
    logic       r;
    logic       stall;
    logic       cv;
    logic [1:0] ty;
    logic       ct;
    logic       ca;
    logic       an;
    logic       ar;
  } in_t;

  typedef struct packed {
    logic       pc_le;
    logic       npc_le;
    logic       ifid_le;
    logic       ch_clear;
    logic [1:0] mux_sel;
    logic       busy;
  } out_t;

  typedef struct {
    in_t         in;
    logic [31:0] ta;
    logic [31:0] alu;
    bit          chk_out;
    out_t        exp;
    logic [31:0] pc;
    logic [31:0] npc;
  } vec_t;

  logic        clk;
  in_t         cur;
  logic [31:0] ta, alu, pc, npc, src;
  int          total, bad;
  vec_t        vecs[$];

  if_fetch_ctrl_if bus_a ();
  if_fetch_ctrl_if bus_b ();

  assign bus_a.stall_in    = cur.stall;
  assign bus_a.cti_valid   = cur.cv;
  assign bus_a.cti_type    = cur.ty;
  assign bus_a.cond_true   = cur.ct;
  assign bus_a.cond_always = cur.ca;
  assign bus_a.annul       = cur.an;
  assign bus_a.alu_ready   = cur.ar;
  assign bus_b.stall_in    = cur.stall;
  assign bus_b.cti_valid   = cur.cv;
  assign bus_b.cti_type    = cur.ty;
  assign bus_b.cond_true   = cur.ct;
  assign bus_b.cond_always = cur.ca;
  assign bus_b.annul       = cur.an;
  assign bus_b.alu_ready   = cur.ar;

  if_fetch_ctrl #(.STARTUP_CYCLES(1), .CNT_W(4)) dut_a (.clk(clk), .R(cur.r), .bus(bus_a));
  if_fetch_ctrl #(.STARTUP_CYCLES(3), .CNT_W(4)) dut_b (.clk(clk), .R(cur.r), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC/nPC datapath driven by dut_a's enables
  always_comb begin
    case (bus_a.mux_sel)
      2'b00:   src = npc;
      2'b01:   src = ta;
      2'b10:   src = alu;
      default: src = 32'hdead_beef;
    endcase
  end

  always @(posedge clk) begin
    if (cur.r) begin
      pc  <= 32'h0;
      npc <= 32'h4;
    end else begin
      if (bus_a.pc_le)  pc  <= src;
      if (bus_a.npc_le) npc <= src + 32'h4;
    end
  end

  function automatic out_t model_out(int left, bit waiting, in_t i);
    out_t o        = '0;
    bit   jmpl     = i.cv && i.ty == 2'b10;
    bit   redirect = i.cv && (i.ty == 2'b01 || (i.ty == 2'b00 && i.ct));
    if (left > 0) begin
      o.ch_clear = 1'b1;
      o.busy     = 1'b1;
    end else if (waiting) begin
      o.ch_clear = 1'b1;
      o.busy     = 1'b1;
      if (i.ar && !i.stall) begin
        o.pc_le   = 1'b1;
        o.npc_le  = 1'b1;
        o.mux_sel = 2'b10;
      end
    end else if (i.stall) begin
      o = '0;
    end else if (jmpl) begin
      o.ifid_le = 1'b1;
    end else begin
      o.pc_le    = 1'b1;
      o.npc_le   = 1'b1;
      o.ifid_le  = 1'b1;
      o.mux_sel  = redirect ? 2'b01 : 2'b00;
      o.ch_clear = i.cv && i.ty == 2'b00 && i.an && (!i.ct || i.ca);
    end
    return o;
  endfunction

  task automatic model_step(input in_t i, input int n, inout int left, inout bit waiting);
    if (i.r) begin
      left    = n;
      waiting = 1'b0;
    end else if (left > 0) begin
      left = left - 1;
    end else if (waiting) begin
      if (i.ar && !i.stall) waiting = 1'b0;
    end else if (!i.stall && i.cv && i.ty == 2'b10) begin
      waiting = 1'b1;
    end
  endtask

  function automatic in_t mk_in(bit r, bit st, bit cv, bit [1:0] ty, bit ct, bit ca, bit an, bit ar);
    return {r, st, cv, ty, ct, ca, an, ar};
  endfunction

  function automatic out_t mk_out(bit pl, bit nl, bit il, bit cc, bit [1:0] ms, bit bz);
    return {pl, nl, il, cc, ms, bz};
  endfunction

  task automatic add(input in_t i, input logic [31:0] t, input logic [31:0] a, input bit c,
                     input out_t e, input logic [31:0] p, input logic [31:0] np);
    vec_t v;
    v.in = i; v.ta = t; v.alu = a; v.chk_out = c; v.exp = e; v.pc = p; v.npc = np;
    vecs.push_back(v);
  endtask

  task automatic chk_out(input string name, input int idx, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%b exp=%b (pl,nl,il,cc,ms,bz)", name, idx, got, exp);
    end
  endtask

  task automatic chk32(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  function automatic out_t got_a();
    return {bus_a.pc_le, bus_a.npc_le, bus_a.ifid_le, bus_a.ch_clear, bus_a.mux_sel, bus_a.busy};
  endfunction

  function automatic out_t got_b();
    return {bus_b.pc_le, bus_b.npc_le, bus_b.ifid_le, bus_b.ch_clear, bus_b.mux_sel, bus_b.busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   left_a, left_b;
    bit   wait_a, wait_b;
    out_t none;
    none  = '0;
    total = 0;
    bad   = 0;
    cur   = mk_in(1, 0, 0, 0, 0, 0, 0, 0);
    ta    = '0;
    alu   = '0;

    //   r st cv ty ct ca an ar           ta       alu       chk   pl nl il cc ms bz        pc      npc
    add(mk_in(1,0,0,0,0,0,0,0), 0,       0,       0, none,                    32'h0,   32'h4);
    add(mk_in(1,0,0,0,0,0,0,0), 0,       0,       1, mk_out(0,0,0,1,2'b00,1), 32'h0,   32'h4);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       0,       1, mk_out(0,0,0,1,2'b00,1), 32'h0,   32'h4);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       0,       1, mk_out(1,1,1,0,2'b00,0), 32'h4,   32'h8);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       0,       1, mk_out(1,1,1,0,2'b00,0), 32'h8,   32'hc);
    add(mk_in(0,0,1,0,1,0,0,0), 32'h40,  0,       1, mk_out(1,1,1,0,2'b01,0), 32'h40,  32'h44);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       0,       1, mk_out(1,1,1,0,2'b00,0), 32'h44,  32'h48);
    add(mk_in(0,0,1,0,0,0,1,0), 32'h90,  0,       1, mk_out(1,1,1,1,2'b00,0), 32'h48,  32'h4c);
    add(mk_in(0,0,1,0,1,1,1,0), 32'h80,  0,       1, mk_out(1,1,1,1,2'b01,0), 32'h80,  32'h84);
    add(mk_in(0,0,1,0,1,0,1,0), 32'h20,  0,       1, mk_out(1,1,1,0,2'b01,0), 32'h20,  32'h24);
    add(mk_in(0,0,1,1,0,0,1,0), 32'h200, 0,       1, mk_out(1,1,1,0,2'b01,0), 32'h200, 32'h204);
    add(mk_in(0,0,1,2,0,0,0,0), 0,       32'h100, 1, mk_out(0,0,1,0,2'b00,0), 32'h200, 32'h204);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       32'h100, 1, mk_out(0,0,0,1,2'b00,1), 32'h200, 32'h204);
    add(mk_in(0,0,0,0,0,0,0,0), 0,       32'h100, 1, mk_out(0,0,0,1,2'b00,1), 32'h200, 32'h204);
    add(mk_in(0,0,0,0,0,0,0,1), 0,       32'h100, 1, mk_out(1,1,0,1,2'b10,1), 32'h100, 32'h104);
    add(mk_in(0,1,1,0,1,0,0,0), 32'h300, 0,       1, mk_out(0,0,0,0,2'b00,0), 32'h100, 32'h104);
    add(mk_in(0,1,1,0,1,0,0,0), 32'h300, 0,       1, mk_out(0,0,0,0,2'b00,0), 32'h100, 32'h104);
    add(mk_in(0,0,1,0,1,0,0,0), 32'h300, 0,       1, mk_out(1,1,1,0,2'b01,0), 32'h300, 32'h304);
    add(mk_in(0,0,1,2,0,0,0,0), 0,       0,       1, mk_out(0,0,1,0,2'b00,0), 32'h300, 32'h304);
    add(mk_in(0,1,0,0,0,0,0,1), 0,       32'h500, 1, mk_out(0,0,0,1,2'b00,1), 32'h300, 32'h304);
    add(mk_in(1,0,0,0,0,0,0,0), 0,       32'h500, 1, mk_out(0,0,0,1,2'b00,1), 32'h0,   32'h4);
    add(mk_in(0,0,1,2,0,0,0,1), 0,       32'h500, 1, mk_out(0,0,0,1,2'b00,1), 32'h0,   32'h4);
    add(mk_in(0,0,0,0,0,0,0,1), 0,       32'h500, 1, mk_out(1,1,1,0,2'b00,0), 32'h4,   32'h8);
    add(mk_in(0,0,1,3,1,1,1,0), 32'h700, 0,       1, mk_out(1,1,1,0,2'b00,0), 32'h8,   32'hc);

    foreach (vecs[k]) begin
      @(negedge clk);
      cur = vecs[k].in;
      ta  = vecs[k].ta;
      alu = vecs[k].alu;
      #1;
      if (vecs[k].chk_out) chk_out("vec_out", k, got_a(), vecs[k].exp);
      @(posedge clk);
      #1;
      chk32("vec_pc", k, pc, vecs[k].pc);
      chk32("vec_npc", k, npc, vecs[k].npc);
    end

    // Randomized run: both start-up lengths against the reference model
    @(negedge clk);
    cur = mk_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    left_a = 1; left_b = 3; wait_a = 1'b0; wait_b = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      cur.r     = ($urandom_range(0, 39) == 0);
      cur.stall = ($urandom_range(0, 4) == 0);
      cur.cv    = $urandom_range(0, 1) != 0;
      cur.ty    = 2'($urandom_range(0, 3));
      cur.ct    = $urandom_range(0, 1) != 0;
      cur.ca    = $urandom_range(0, 1) != 0;
      cur.an    = $urandom_range(0, 1) != 0;
      cur.ar    = ($urandom_range(0, 2) == 0);
      ta        = $urandom;
      alu       = $urandom;
      #1;
      chk_out("rand_a", k, got_a(), model_out(left_a, wait_a, cur));
      chk_out("rand_b", k, got_b(), model_out(left_b, wait_b, cur));
      @(posedge clk);
      model_step(cur, 1, left_a, wait_a);
      model_step(cur, 3, left_b, wait_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
